// File: rtl/prv32_div_seq_if.sv
// Request/response and shared-ALU signal bundle for the sequential divider.
// The slave side is the divider; the master side is the requester plus the shared ALU.
interface prv32_div_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_fn;
    logic [31:0] alu_r;
    logic        alu_cf;

    modport master (
        output start, op, dividend, divisor, alu_r, alu_cf,
        input  busy, done, result, alu_a, alu_b, alu_shamt, alu_fn
    );

    modport slave (
        input  start, op, dividend, divisor, alu_r, alu_cf,
        output busy, done, result, alu_a, alu_b, alu_shamt, alu_fn
    );
endinterface

// File: rtl/prv32_div_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU/REM/REMU) that borrows an external
// shared ALU for every subtraction, including sign fix-up of operands and result.
module prv32_div_seq (
    input logic             clk,
    input logic             rst_n,
    prv32_div_seq_if.slave  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ABS_A = 3'd1;
    localparam logic [2:0] ABS_B = 3'd2;
    localparam logic [2:0] ITER  = 3'd3;
    localparam logic [2:0] FIX   = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]  state;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic        sa;
    logic        sb;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] b_abs;
    logic [31:0] rem;
    logic [31:0] q;
    logic [31:0] result_q;

    logic [31:0] rem_sh;
    logic        take;
    logic        negate;
    logic [31:0] alu_a_c;
    logic [31:0] alu_b_c;
    logic [3:0]  alu_fn_c;

    // rem[31] set means the shifted partial remainder exceeds 32 bits, so it always covers |b|
    assign rem_sh = {rem[30:0], q[31]};
    assign take   = rem[31] | bus.alu_cf;
    assign negate = op_q[1] ? sa : (sa ^ sb);

    always_comb begin
        alu_a_c  = '0;
        alu_b_c  = '0;
        alu_fn_c = 4'b0000;
        case (state)
            ABS_A: begin
                alu_fn_c = 4'b0001;
                alu_b_c  = a_q;
            end
            ABS_B: begin
                alu_fn_c = 4'b0001;
                alu_b_c  = b_q;
            end
            ITER: begin
                alu_fn_c = 4'b0001;
                alu_a_c  = rem_sh;
                alu_b_c  = b_abs;
            end
            FIX: begin
                alu_fn_c = 4'b0001;
                alu_b_c  = op_q[1] ? rem : q;
            end
            default: ;
        endcase
    end

    assign bus.alu_a     = alu_a_c;
    assign bus.alu_b     = alu_b_c;
    assign bus.alu_fn    = alu_fn_c;
    assign bus.alu_shamt = '0;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.result    = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            b_abs    <= '0;
            rem      <= '0;
            q        <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.op;
                        a_q  <= bus.dividend;
                        b_q  <= bus.divisor;
                        sa   <= ~bus.op[0] & bus.dividend[31];
                        sb   <= ~bus.op[0] & bus.divisor[31];
                        if (bus.divisor == '0) begin
                            result_q <= bus.op[1] ? bus.dividend : '1;
                            state    <= DONE;
                        end else begin
                            state <= ABS_A;
                        end
                    end
                end
                ABS_A: begin
                    q     <= sa ? bus.alu_r : a_q;
                    rem   <= '0;
                    state <= ABS_B;
                end
                ABS_B: begin
                    b_abs <= sb ? bus.alu_r : b_q;
                    cnt   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    rem <= take ? bus.alu_r : rem_sh;
                    q   <= {q[30:0], take};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    result_q <= negate ? bus.alu_r : alu_b_c;
                    state    <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prv32_div_seq.sv
// Scoreboard bench for prv32_div_seq: random and corner-case operations against an
// arithmetic reference model, with a behavioural shared ALU.
module tb_prv32_div_seq;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_err;

    prv32_div_seq_if bus ();

    prv32_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared ALU: 0001 subtract with no-borrow carry, anything else add.
    always_comb begin
        if (bus.alu_fn == 4'b0001) begin
            bus.alu_r  = bus.alu_a - bus.alu_b;
            bus.alu_cf = (bus.alu_a >= bus.alu_b);
        end else begin
            {bus.alu_cf, bus.alu_r} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        end
    end

    typedef struct {
        logic [31:0] res;
        int          at;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    logic [31:0] last_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int sa_i;
        int sb_i;
        sa_i = a;
        sb_i = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'b00: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa_i / sb_i;
            end
            2'b01: return a / b;
            2'b10: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa_i % sb_i;
            end
            default: return a % b;
        endcase
    endfunction

    // Monitor: every done pops the oldest expectation; result must hold otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_res = '0;
        end else if (bus.done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.tag, "_result"}, bus.result, e.res);
                chk({e.tag, "_latency"}, cyc, e.at);
            end
            last_res = bus.result;
        end else if (!bus.busy) begin
            chk("result_hold", bus.result, last_res);
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        if (i == 100) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Called at a negedge; drives start for one cycle and records the expectation.
    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bool_poke);
        exp_t e;
        bus.start    = 1'b1;
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        e.res = ref_model(op, a, b);
        e.at  = cyc + ((b == 32'd0) ? 1 : 36);
        e.tag = $sformatf("op%0d_%h_%h", op, a, b);
        sb_q.push_back(e);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        if (bool_poke) begin
            repeat (8) @(negedge clk);
            bus.start    = 1'b1;
            bus.op       = ~op;
            bus.dividend = $urandom;
            bus.divisor  = 32'd0;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_idle();
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(op, a, b, 1'b0);
    endtask

    typedef bit bool_poke;

    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        n_vec = 0;
        n_err = 0;
        last_res = '0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.dividend = '0;
        bus.divisor = '0;
        #1;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        chk("reset_alu_a", bus.alu_a, 32'd0);
        chk("reset_alu_b", bus.alu_b, 32'd0);
        repeat (3) @(negedge clk);

        // Start presented together with reset release: taken on the first rising edge.
        rst_n = 1'b1;
        drive(2'b01, 32'd100, 32'd7, 1'b0);

        run(2'b11, 32'd100, 32'd7);
        run(2'b00, 32'hFFFF_FFF9, 32'd2);
        run(2'b10, 32'hFFFF_FFF9, 32'd2);
        run(2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
        run(2'b11, 32'hFFFF_FFFF, 32'h8000_0001);
        run(2'b00, 32'd5, 32'd0);
        run(2'b10, 32'd5, 32'd0);
        run(2'b01, 32'd5, 32'd0);
        run(2'b11, 32'hDEAD_BEEF, 32'd0);
        run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b00, 32'h8000_0000, 32'd1);
        run(2'b10, 32'h7FFF_FFFF, 32'h8000_0000);

        // Start pulsed mid-operation must be ignored.
        @(negedge clk);
        drive(2'b00, 32'hFFFF_FF9C, 32'd7, 1'b1);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = rb >> $urandom_range(0, 31);
                1: rb = 32'd0;
                2: ra = ra >> $urandom_range(0, 31);
                3: rb = 32'hFFFF_FFFF - (rb & 32'h3);
                default: ;
            endcase
            run(2'($urandom_range(0, 3)), ra, rb);
        end

        // Reset during ITER aborts with no done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'b01;
        bus.dividend = 32'h1234_5678;
        bus.divisor = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
        chk("midreset_result", bus.result, 32'd0);
        chk("midreset_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        run(2'b10, 32'd100, 32'hFFFF_FFF9);
        repeat (3) @(negedge clk);

        if (sb_q.size() != 0) begin
            chk("pending_expectations", sb_q.size(), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/prv32_div_seq.md
PRV32_DIV_SEQ -- requirements
Module: prv32_div_seq

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 dividend  input  32  operand a; sampled with start.
REQ-007 divisor  input  32  operand b; sampled with start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  32  registered quotient or remainder; held until the next done.
REQ-011 alu_a  output  32  shared ALU operand a.
REQ-012 alu_b  output  32  shared ALU operand b.
REQ-013 alu_shamt  output  5  shared ALU shift amount; constant 0.
REQ-014 alu_fn  output  4  shared ALU function; 4'b0001 (subtract) in ABS_A, ABS_B, ITER and FIX; 4'b0000 otherwise.
REQ-015 alu_r  input  32  shared ALU result, combinational from alu_a, alu_b and alu_fn.
REQ-016 alu_cf  input  1  shared ALU carry; 1 means no borrow (alu_a >= alu_b, unsigned) when subtracting.

Function
REQ-017 FSM states SHALL be IDLE, ABS_A, ABS_B, ITER, FIX and DONE.
- IDLE->ABS_A on start with divisor != 0.
- IDLE->DONE on start with divisor == 0.
- ABS_A->ABS_B->ITER.
- ITER->FIX after 32 iterations.
- FIX->DONE; DONE->IDLE unconditionally.
REQ-018 On an accepted start, the block SHALL latch op, dividend and divisor.
- Signed flag: op[0]==0.
- sa = signed & dividend[31]; sb = signed & divisor[31].
REQ-019 ABS_A SHALL drive alu_a=0 and alu_b=dividend, and latch |a| = sa ? alu_r : dividend.
REQ-020 ABS_B SHALL drive alu_a=0 and alu_b=divisor, and latch |b| = sb ? alu_r : divisor.
REQ-021 ITER SHALL use a 5-bit counter starting at 0 and perform one restoring step per cycle.
- rem_sh = {rem[30:0], q[31]}; q is then shifted left.
- alu_a = rem_sh; alu_b = |b|.
- take = rem[31] | alu_cf.
- rem <= take ? alu_r : rem_sh; new q LSB = take.
- rem SHALL start at 0 and q SHALL start at |a|.
- Counter wraps at 31 and ends ITER.
REQ-022 FIX SHALL drive alu_a=0; alu_b = q for DIV/DIVU, rem for REM/REMU.
- result <= alu_r when negation is needed, else alu_b.
- Quotient is negated when sa^sb; remainder is negated when sa.
REQ-023 Divide by zero SHALL set result to 0xFFFFFFFF for DIV/DIVU and to dividend for REM/REMU.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 through the normal path, with no special-casing.
REQ-025 Latency is fixed, regardless of operand signs:
- Normal operation: done SHALL be high in the 36th cycle after the start-sampling edge.
- Divide by zero: done SHALL be high in the 1st cycle after that edge.
REQ-026 done SHALL be high only in DONE, and result SHALL be valid whenever done is high.
REQ-027 start while busy (including DONE) SHALL be ignored; no queuing.
REQ-028 In IDLE and DONE, alu_a and alu_b SHALL be 0.

Reset
REQ-029 While rst_n=0, asynchronously: state=IDLE, busy=0, done=0, result=0, counter=0, internal operands=0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-031 The first start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-032 DIVU 100/7 -> result=14 with done at cycle 36; REMU 100/7 -> result=2.
REQ-033 DIV 0xFFFFFFF9/2 -> result=0xFFFFFFFD; REM 0xFFFFFFF9/2 -> result=0xFFFFFFFF.
REQ-034 DIVU 0xFFFFFFFF/0x80000001 -> result=1; REMU -> result=0x7FFFFFFE (exercises the rem[31] path).
REQ-035 DIV 5/0 -> result=0xFFFFFFFF with done at cycle 1; REM 5/0 -> result=5.
REQ-036 DIV 0x80000000/0xFFFFFFFF -> result=0x80000000; REM -> result=0.
REQ-037 rst_n low during ITER -> busy=0 and result=0 immediately; start pulsed at cycle 10 of an operation -> ignored, and the original result is unchanged.
